// File: rtl/sync_counter_mode_pkg.sv
// -----------------------------------------------------------------------------
// sync_cnt_pkg
// Shared types and defaults for the sync_counter_mode counter slice.
//   cnt_mode_e       : terminal behaviour selector (wrap / saturate / one-shot)
//   DEFAULT_WIDTH    : default counter width
//   DEFAULT_PRESCALE : default enable cycles per count step
//   isWrapMode()     : true for modes that wrap at the terminal value
// Optional feature macro used by the slice: SYNC_CNT_PRESCALE_EN
// -----------------------------------------------------------------------------
package sync_cnt_pkg;

  // Terminal modes; the reserved encoding is decoded as wrap so that a
  // stray value on mode_i never freezes the counter.
  typedef enum logic [1:0] {
    CNT_WRAP    = 2'd0,
    CNT_SAT     = 2'd1,
    CNT_ONESHOT = 2'd2,
    CNT_RSVD    = 2'd3
  } cnt_mode_e;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_PRESCALE = 4;

  // Wrap and reserved share the same terminal action.
  function automatic logic isWrapMode(input cnt_mode_e mode);
    return (mode == CNT_WRAP) || (mode == CNT_RSVD);
  endfunction

endpackage

// File: rtl/sync_counter_mode_if.sv
// -----------------------------------------------------------------------------
// sync_counter_mode_if
// Control/status bundle between a counter user (master) and the counter
// (slave). Names carry the direction as seen from the counter.
//   en_i, clr_i, load_i, load_val_i, limit_i, dir_i, mode_i : to counter
//   counter_o, end_o, done_o                                : from counter
// Parameter WIDTH must match the WIDTH of the attached counter.
// -----------------------------------------------------------------------------
interface sync_counter_mode_if
  import sync_cnt_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             en_i;
  logic             clr_i;
  logic             load_i;
  logic [WIDTH-1:0] load_val_i;
  logic [WIDTH-1:0] limit_i;
  logic             dir_i;
  cnt_mode_e        mode_i;
  logic [WIDTH-1:0] counter_o;
  logic             end_o;
  logic             done_o;

  // The user of the counter drives controls and observes status.
  modport master (
    output en_i, clr_i, load_i, load_val_i, limit_i, dir_i, mode_i,
    input  counter_o, end_o, done_o
  );

  // The counter itself.
  modport slave (
    input  en_i, clr_i, load_i, load_val_i, limit_i, dir_i, mode_i,
    output counter_o, end_o, done_o
  );

endinterface

// File: rtl/sync_counter_mode_prescaler.sv
// -----------------------------------------------------------------------------
// cnt_prescaler
// Divides the count enable so the main counter steps once every PRESCALE
// enabled cycles. Only instantiated when SYNC_CNT_PRESCALE_EN is defined.
//   clk    : system clock, rising edge
//   nrst   : asynchronous active-low reset
//   en_i   : count enable; the phase only advances on enabled cycles
//   clr_i  : synchronous phase clear (driven by counter clear or load)
//   tick_o : high on the enabled cycle that completes a PRESCALE group
// Parameter PRESCALE >= 1; PRESCALE = 1 ticks on every enabled cycle.
// -----------------------------------------------------------------------------
module cnt_prescaler
  import sync_cnt_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic clk,
  input  logic nrst,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  // A one-bit phase register is kept even for PRESCALE = 1; it simply
  // never leaves zero, which keeps the declarations legal for every value.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'(PRESCALE - 1);

  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;

  // Next phase: clear wins, otherwise advance on enable and roll over after
  // the last phase so the following group starts cleanly from zero.
  always_comb begin
    phase_d = phase_q;
    if (clr_i) begin
      phase_d = '0;
    end else if (en_i) begin
      if (phase_q == LAST_PHASE) begin
        phase_d = '0;
      end else begin
        phase_d = phase_q + PW'(1);
      end
    end
  end

  // Phase register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  // The tick coincides with the enabled cycle sitting on the last phase.
  assign tick_o = en_i & (phase_q == LAST_PHASE);

endmodule

// File: rtl/sync_counter_mode.sv
// -----------------------------------------------------------------------------
// sync_counter_mode
// Width-generic up/down counter with a runtime limit and three terminal
// modes (wrap, saturate, one-shot), synchronous clear and load. Used as the
// timer/sequencer primitive for the exercise designs.
//   clk            : system clock, rising edge
//   nrst           : asynchronous active-low reset
//   bus (slave)    : sync_counter_mode_if
//     en_i         : count enable
//     clr_i        : synchronous clear (highest priority)
//     load_i       : synchronous load of min(load_val_i, limit_i)
//     load_val_i   : load value
//     limit_i      : up-count terminal value / down-count reload value
//     dir_i        : 0 = up, 1 = down
//     mode_i       : cnt_mode_e terminal mode
//     counter_o    : registered count
//     end_o        : registered one-cycle pulse on reaching the terminal
//     done_o       : registered sticky one-shot completion flag
// Parameters: WIDTH (>= 2), PRESCALE (>= 1, only with the macro below).
// Optional feature: define SYNC_CNT_PRESCALE_EN to step once every PRESCALE
// enabled cycles instead of every enabled cycle.
// -----------------------------------------------------------------------------
module sync_counter_mode
  import sync_cnt_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input logic                clk,
  input logic                nrst,
  sync_counter_mode_if.slave bus
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             end_q;
  logic             end_d;
  logic             done_q;
  logic             done_d;

  logic             tick;
  logic             stepEn;
  logic             atTerminal;
  logic [WIDTH-1:0] terminalVal;

`ifdef SYNC_CNT_PRESCALE_EN
  // Clear and load both restart the prescale phase so a fresh count always
  // waits a full PRESCALE group before its first step.
  cnt_prescaler #(
    .PRESCALE (PRESCALE)
  ) uPrescaler (
    .clk    (clk),
    .nrst   (nrst),
    .en_i   (bus.en_i),
    .clr_i  (bus.clr_i | bus.load_i),
    .tick_o (tick)
  );
`else
  // Without the prescaler every enabled cycle is a step candidate.
  localparam int unusedPrescale = PRESCALE;
  assign tick = 1'b1;
`endif

  // A finished one-shot refuses further steps until cleared or reloaded.
  assign stepEn = bus.en_i & tick & ~done_q;

  // Terminal detection. An up-count sitting above a lowered limit is treated
  // as terminal so the terminal action pulls it back into range instead of
  // letting it run on towards the top of the range.
  always_comb begin
    terminalVal = '0;
    atTerminal  = 1'b0;
    if (bus.dir_i) begin
      terminalVal = '0;
      atTerminal  = (count_q == '0);
    end else begin
      terminalVal = bus.limit_i;
      atTerminal  = (count_q >= bus.limit_i);
    end
  end

  // Next-state logic with priority clear > load > step. end_d is raised only
  // when a step lands on the terminal value; a hold at the terminal (saturate
  // or one-shot) never produces a new pulse, while a wrap that lands back on
  // the terminal (limit of zero) does, once per step.
  always_comb begin
    count_d = count_q;
    done_d  = done_q;
    end_d   = 1'b0;
    if (bus.clr_i) begin
      count_d = '0;
      done_d  = 1'b0;
    end else if (bus.load_i) begin
      count_d = (bus.load_val_i > bus.limit_i) ? bus.limit_i : bus.load_val_i;
      done_d  = 1'b0;
    end else if (stepEn) begin
      if (atTerminal) begin
        if (isWrapMode(bus.mode_i)) begin
          count_d = bus.dir_i ? bus.limit_i : '0;
          end_d   = (count_d == terminalVal);
        end else if (bus.mode_i == CNT_ONESHOT) begin
          done_d = 1'b1;
        end
      end else begin
        count_d = bus.dir_i ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
        end_d   = (count_d == terminalVal);
      end
    end
  end

  // State and output registers; reset takes effect immediately.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count_q <= '0;
      end_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      end_q   <= end_d;
      done_q  <= done_d;
    end
  end

  // Outputs come straight from flops.
  assign bus.counter_o = count_q;
  assign bus.end_o     = end_q;
  assign bus.done_o    = done_q;

endmodule

// File: tb/tb_sync_counter_mode.sv
// -----------------------------------------------------------------------------
// tb_sync_counter_mode
// Directed bench for sync_counter_mode at WIDTH = 8, PRESCALE = 4.
// With SYNC_CNT_PRESCALE_EN defined only the prescaler sequence is run,
// otherwise the functional sequences for the plain counter are run.
// -----------------------------------------------------------------------------
module tb_sync_counter_mode;
  import sync_cnt_pkg::*;

  logic clk;
  logic nrst;
  int   total;
  int   bad;

  int   upExp [8] = '{1, 2, 3, 4, 5, 0, 1, 2};
  int   dnExp [5] = '{2, 1, 0, 0, 0};
  int   dnEnd [5] = '{0, 0, 1, 0, 0};

  sync_counter_mode_if #(.WIDTH(8)) bus ();

  sync_counter_mode #(
    .WIDTH    (8),
    .PRESCALE (4)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Drive one cycle of inputs, then let one rising edge pass and settle 1 ns.
  task automatic applyStimulus(input logic en, input logic clr, input logic load,
                               input logic [7:0] loadVal, input logic [7:0] limit,
                               input logic dir, input cnt_mode_e mode);
    bus.en_i       = en;
    bus.clr_i      = clr;
    bus.load_i     = load;
    bus.load_val_i = loadVal;
    bus.limit_i    = limit;
    bus.dir_i      = dir;
    bus.mode_i     = mode;
    @(posedge clk);
    #1;
  endtask

  // Compare all three outputs against hand-computed expectations.
  task automatic checkOutput(input string tag, input logic [7:0] expCount,
                             input logic expEnd, input logic expDone);
    total++;
    assert (bus.counter_o === expCount) else begin
      bad++;
      $error("[TB] FAIL %s counter_o got %0d expected %0d", tag, bus.counter_o, expCount);
    end
    total++;
    assert (bus.end_o === expEnd) else begin
      bad++;
      $error("[TB] FAIL %s end_o got %0b expected %0b", tag, bus.end_o, expEnd);
    end
    total++;
    assert (bus.done_o === expDone) else begin
      bad++;
      $error("[TB] FAIL %s done_o got %0b expected %0b", tag, bus.done_o, expDone);
    end
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    nrst           = 1'b0;
    bus.en_i       = 1'b0;
    bus.clr_i      = 1'b0;
    bus.load_i     = 1'b0;
    bus.load_val_i = 8'd0;
    bus.limit_i    = 8'd5;
    bus.dir_i      = 1'b0;
    bus.mode_i     = CNT_WRAP;

    #3;
    checkOutput("reset", 8'd0, 1'b0, 1'b0);
    #9;
    nrst = 1'b1;

`ifdef SYNC_CNT_PRESCALE_EN
    $display("[TB] prescaler sequence");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 8'd3, 1'b0, CNT_WRAP);
    checkOutput("psClear", 8'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 8'd3, 1'b0, CNT_WRAP);
      checkOutput($sformatf("psRun%0d", i), 8'(i / 4), (i == 12), 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 1'b1, 8'd0, 8'd3, 1'b0, CNT_WRAP);
    checkOutput("psLoad", 8'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 8'd3, 1'b0, CNT_WRAP);
      checkOutput($sformatf("psPhase%0d", i), (i == 4) ? 8'd1 : 8'd0, 1'b0, 1'b0);
    end
`else
    $display("[TB] up wrap and async reset");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 8'd5, 1'b0, CNT_WRAP);
      checkOutput($sformatf("upWrap%0d", i), 8'(upExp[i]), (upExp[i] == 5), 1'b0);
    end
    #2;
    nrst = 1'b0;
    #1;
    checkOutput("asyncReset", 8'd0, 1'b0, 1'b0);
    #2;
    nrst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 8'd5, 1'b0, CNT_WRAP);
    checkOutput("resume", 8'd1, 1'b0, 1'b0);

    $display("[TB] down saturate");
    applyStimulus(1'b1, 1'b0, 1'b1, 8'd3, 8'd5, 1'b1, CNT_SAT);
    checkOutput("dsLoad", 8'd3, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd3, 8'd5, 1'b1, CNT_SAT);
      checkOutput($sformatf("downSat%0d", i), 8'(dnExp[i]), dnEnd[i][0], 1'b0);
    end

    $display("[TB] one-shot up");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 8'd2, 1'b0, CNT_ONESHOT);
    checkOutput("osClear", 8'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 8'd2, 1'b0, CNT_ONESHOT);
    checkOutput("os1", 8'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 8'd2, 1'b0, CNT_ONESHOT);
    checkOutput("os2", 8'd2, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 8'd2, 1'b0, CNT_ONESHOT);
    checkOutput("osDone", 8'd2, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 8'd2, 1'b0, CNT_ONESHOT);
    checkOutput("osHold", 8'd2, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 8'd2, 1'b0, CNT_ONESHOT);
    checkOutput("osClr", 8'd0, 1'b0, 1'b0);

    $display("[TB] priority and limits");
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd9, 8'd10, 1'b0, CNT_WRAP);
    checkOutput("clrOverLoad", 8'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd200, 8'd10, 1'b0, CNT_WRAP);
    checkOutput("loadClamp", 8'd10, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'd7, 8'd10, 1'b0, CNT_WRAP);
    checkOutput("load7", 8'd7, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd7, 8'd4, 1'b0, CNT_WRAP);
    checkOutput("limitLowered", 8'd0, 1'b0, 1'b0);

    $display("[TB] enable gating and direction flip");
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 8'd4, 1'b0, CNT_WRAP);
    checkOutput("gateOff0", 8'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 8'd4, 1'b0, CNT_WRAP);
    checkOutput("gateOn1", 8'd1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 8'd4, 1'b0, CNT_WRAP);
    checkOutput("gateOff1", 8'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 8'd4, 1'b0, CNT_WRAP);
    checkOutput("gateOn2", 8'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 8'd4, 1'b1, CNT_WRAP);
    checkOutput("dirFlip", 8'd1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 8'd4, 1'b1, CNT_WRAP);
    checkOutput("dirGateOff", 8'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 8'd4, 1'b1, CNT_WRAP);
    checkOutput("downToZero", 8'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 8'd4, 1'b1, CNT_WRAP);
    checkOutput("downReload", 8'd4, 1'b0, 1'b0);

    $display("[TB] zero limit");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, CNT_WRAP);
    checkOutput("zeroWrapA", 8'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, CNT_WRAP);
    checkOutput("zeroWrapB", 8'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, CNT_SAT);
    checkOutput("zeroSat", 8'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, CNT_ONESHOT);
    checkOutput("zeroOneShot", 8'd0, 1'b0, 1'b1);

    $display("[TB] reserved mode wraps");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 8'd3, 1'b0, CNT_RSVD);
    checkOutput("rsvdClr", 8'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 8'd3, 1'b0, CNT_RSVD);
      checkOutput($sformatf("rsvd%0d", i), 8'(i % 4), (i == 3), 1'b0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
